// File: rtl/abro_stim_driver.sv
// Stimulus driver for an ABRO state machine: raises A and B after programmable delays, then checks when O responds.
// Optional err_count output is enabled by defining ABRO_DRV_ERRCNT_EN.
module abro_stim_driver #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] delay_a,
    input  logic [CNT_W-1:0] delay_b,
    input  logic             O,
    output logic             A,
    output logic             B,
    output logic             R,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       State
`ifdef ABRO_DRV_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RESTART = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  run_cnt, run_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  dly_a, dly_a_nxt;
    logic [CNT_W-1:0]  dly_b, dly_b_nxt;
    logic              pass_nxt, fail_nxt;
    logic              fail_set;
    logic              a_hit, b_hit;

    assign a_hit = (run_cnt >= dly_a);
    assign b_hit = (run_cnt >= dly_b);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            run_cnt  <= '0;
            wait_cnt <= '0;
            dly_a    <= '0;
            dly_b    <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            dly_a    <= dly_a_nxt;
            dly_b    <= dly_b_nxt;
            pass     <= pass_nxt;
            fail     <= fail_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt    = state;
        run_cnt_nxt  = run_cnt;
        wait_cnt_nxt = wait_cnt;
        dly_a_nxt    = dly_a;
        dly_b_nxt    = dly_b;
        pass_nxt     = pass;
        fail_nxt     = fail;
        fail_set     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    dly_a_nxt    = delay_a;
                    dly_b_nxt    = delay_b;
                    pass_nxt     = 1'b0;
                    fail_nxt     = 1'b0;
                    run_cnt_nxt  = '0;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                if (run_cnt != CNT_MAX) begin
                    run_cnt_nxt = run_cnt + CNT_W'(1);
                end
                // An early O is a failure even if A and B both rose this cycle
                if (O) begin
                    fail_nxt  = 1'b1;
                    fail_set  = 1'b1;
                    state_nxt = S_RESTART;
                end else if (a_hit && b_hit) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (O) begin
                    pass_nxt  = 1'b1;
                    state_nxt = S_RESTART;
                end else if (wait_cnt == WAIT_LAST) begin
                    fail_nxt  = 1'b1;
                    fail_set  = 1'b1;
                    state_nxt = S_RESTART;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_RESTART: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    assign A     = ((state == S_RUN) && a_hit) || (state == S_WAIT);
    assign B     = ((state == S_RUN) && b_hit) || (state == S_WAIT);
    assign R     = (state == S_RESTART);
    assign done  = (state == S_DONE);
    assign busy  = (state == S_RUN) || (state == S_WAIT) ||
                   (state == S_RESTART) || (state == S_DONE);
    assign State = state;

`ifdef ABRO_DRV_ERRCNT_EN
    // Saturating count of failed runs; survives start, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (fail_set && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
